// File: rtl/nx_rbus_retime_pipe.sv
// Register-bus retime stage between the rrb master and a block slave, with
// configurable request/response pipe depth and a per-transaction watchdog.
module nx_rbus_retime_pipe #(
    parameter int unsigned AW         = 16,
    parameter int unsigned DW         = 32,
    parameter int unsigned REQ_STAGES = 1,
    parameter int unsigned RSP_STAGES = 1,
    parameter int unsigned TIMEOUT    = 1024,
    parameter logic [31:0] TO_DATA    = 32'hDEAD_0BAD
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] rrb_blk_addr,
    input  logic          rrb_blk_rd_stb,
    input  logic [DW-1:0] rrb_blk_wr_data,
    input  logic          rrb_blk_wr_stb,
    output logic [AW-1:0] rrb_blkret_addr,
    output logic          rrb_blkret_rd_stb,
    output logic [DW-1:0] rrb_blkret_wr_data,
    output logic          rrb_blkret_wr_stb,
    input  logic          blkret_rrb_ack,
    input  logic          blkret_rrb_err_ack,
    input  logic [DW-1:0] blkret_rrb_rd_data,
    input  logic          blkret_rrb_intr,
    input  logic          blkret_rrb_ecc_error,
    output logic          blk_rrb_ack,
    output logic          blk_rrb_err_ack,
    output logic [DW-1:0] blk_rrb_rd_data,
    output logic          blk_rrb_intr,
    output logic          blk_rrb_ecc_error,
    output logic          timeout_pulse,
    output logic          drop_pulse
);

    localparam int unsigned CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned REQ_W = AW + DW + 2;
    localparam int unsigned RSP_W = DW + 4;
    localparam logic [CW-1:0] CNT_MAX    = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [DW-1:0] TO_RD_DATA = DW'(TO_DATA);
    localparam bit            WD_EN      = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_pulse_q, timeout_pulse_d;
    logic          drop_pulse_q, drop_pulse_d;

    logic          any_stb;
    logic          any_rsp;
    logic          fwd_stb;
    logic          inject;
    logic          suppress;

    logic [REQ_W-1:0] req_pipe_q [REQ_STAGES];
    logic [REQ_W-1:0] req_pipe_d [REQ_STAGES];
    logic [RSP_W-1:0] rsp_pipe_q [RSP_STAGES];
    logic [RSP_W-1:0] rsp_pipe_d [RSP_STAGES];

    logic          rsp_ack_in;
    logic          rsp_err_in;
    logic [DW-1:0] rsp_data_in;

    assign any_stb = rrb_blk_rd_stb | rrb_blk_wr_stb;
    assign any_rsp = blkret_rrb_ack | blkret_rrb_err_ack;

    // Watchdog FSM; a response arriving on the cnt==TIMEOUT cycle beats the timeout.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        fwd_stb         = 1'b1;
        inject          = 1'b0;
        suppress        = 1'b0;
        timeout_pulse_d = 1'b0;
        drop_pulse_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (any_stb) begin
                    cnt_d   = CNT_ONE;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (any_stb) begin
                    fwd_stb      = 1'b0;
                    drop_pulse_d = 1'b1;
                end
                if (any_rsp) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    inject          = 1'b1;
                    timeout_pulse_d = 1'b1;
                    cnt_d           = CNT_ONE;
                    state_d         = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DRAIN: begin
                if (any_stb) begin
                    fwd_stb      = 1'b0;
                    drop_pulse_d = 1'b1;
                end
                if (any_rsp) begin
                    suppress = 1'b1;
                    state_d  = ST_IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // With the watchdog disabled the block is a pure retime.
        if (!WD_EN) begin
            state_d         = ST_IDLE;
            cnt_d           = '0;
            fwd_stb         = 1'b1;
            inject          = 1'b0;
            suppress        = 1'b0;
            timeout_pulse_d = 1'b0;
            drop_pulse_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            timeout_pulse_q <= 1'b0;
            drop_pulse_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            timeout_pulse_q <= timeout_pulse_d;
            drop_pulse_q    <= drop_pulse_d;
        end
    end

    always_comb begin
        req_pipe_d[0] = {rrb_blk_addr, rrb_blk_wr_data,
                         rrb_blk_rd_stb & fwd_stb, rrb_blk_wr_stb & fwd_stb};
        for (int unsigned i = 1; i < REQ_STAGES; i++) begin
            req_pipe_d[i] = req_pipe_q[i-1];
        end
    end

    always_comb begin
        rsp_ack_in  = blkret_rrb_ack;
        rsp_err_in  = blkret_rrb_err_ack;
        rsp_data_in = blkret_rrb_rd_data;
        if (inject) begin
            rsp_ack_in  = 1'b0;
            rsp_err_in  = 1'b1;
            rsp_data_in = TO_RD_DATA;
        end else if (suppress) begin
            rsp_ack_in  = 1'b0;
            rsp_err_in  = 1'b0;
            rsp_data_in = '0;
        end
    end

    always_comb begin
        rsp_pipe_d[0] = {rsp_ack_in, rsp_err_in, rsp_data_in,
                         blkret_rrb_intr, blkret_rrb_ecc_error};
        for (int unsigned i = 1; i < RSP_STAGES; i++) begin
            rsp_pipe_d[i] = rsp_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < REQ_STAGES; i++) begin
                req_pipe_q[i] <= '0;
            end
            for (int unsigned i = 0; i < RSP_STAGES; i++) begin
                rsp_pipe_q[i] <= '0;
            end
        end else begin
            req_pipe_q <= req_pipe_d;
            rsp_pipe_q <= rsp_pipe_d;
        end
    end

    assign {rrb_blkret_addr, rrb_blkret_wr_data,
            rrb_blkret_rd_stb, rrb_blkret_wr_stb} = req_pipe_q[REQ_STAGES-1];

    assign {blk_rrb_ack, blk_rrb_err_ack, blk_rrb_rd_data,
            blk_rrb_intr, blk_rrb_ecc_error} = rsp_pipe_q[RSP_STAGES-1];

    assign timeout_pulse = timeout_pulse_q;
    assign drop_pulse    = drop_pulse_q;

endmodule

// File: tb/tb_nx_rbus_retime_pipe.sv
// Bench for nx_rbus_retime_pipe: three configurations checked every cycle against a
// timestamp-based transaction model, plus directed literal checks.
module tb_nx_rbus_retime_pipe;

    localparam int unsigned TO_A = 1024;
    localparam int unsigned TO_B = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // shared stimulus for instances A (defaults) and B (TIMEOUT=8)
    logic [15:0] addr;
    logic        rd_stb, wr_stb, ack, err, intr, ecc;
    logic [31:0] wd, rdd;
    // stimulus for instance C (REQ=3, RSP=2, DW=64, TIMEOUT=0)
    logic [15:0] c_addr;
    logic        c_rd, c_wr, c_ack, c_err, c_intr, c_ecc;
    logic [63:0] c_wd, c_rdd;

    logic [15:0] oa_addr, ob_addr, oc_addr;
    logic [31:0] oa_wd, ob_wd, oa_rdd, ob_rdd;
    logic [63:0] oc_wd, oc_rdd;
    logic oa_rd, oa_wr, oa_ack, oa_err, oa_intr, oa_ecc, oa_to, oa_drop;
    logic ob_rd, ob_wr, ob_ack, ob_err, ob_intr, ob_ecc, ob_to, ob_drop;
    logic oc_rd, oc_wr, oc_ack, oc_err, oc_intr, oc_ecc, oc_to, oc_drop;

    nx_rbus_retime_pipe #(.TIMEOUT(TO_A)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .rrb_blk_addr(addr), .rrb_blk_rd_stb(rd_stb), .rrb_blk_wr_data(wd), .rrb_blk_wr_stb(wr_stb),
        .rrb_blkret_addr(oa_addr), .rrb_blkret_rd_stb(oa_rd), .rrb_blkret_wr_data(oa_wd),
        .rrb_blkret_wr_stb(oa_wr),
        .blkret_rrb_ack(ack), .blkret_rrb_err_ack(err), .blkret_rrb_rd_data(rdd),
        .blkret_rrb_intr(intr), .blkret_rrb_ecc_error(ecc),
        .blk_rrb_ack(oa_ack), .blk_rrb_err_ack(oa_err), .blk_rrb_rd_data(oa_rdd),
        .blk_rrb_intr(oa_intr), .blk_rrb_ecc_error(oa_ecc),
        .timeout_pulse(oa_to), .drop_pulse(oa_drop)
    );

    nx_rbus_retime_pipe #(.TIMEOUT(TO_B)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .rrb_blk_addr(addr), .rrb_blk_rd_stb(rd_stb), .rrb_blk_wr_data(wd), .rrb_blk_wr_stb(wr_stb),
        .rrb_blkret_addr(ob_addr), .rrb_blkret_rd_stb(ob_rd), .rrb_blkret_wr_data(ob_wd),
        .rrb_blkret_wr_stb(ob_wr),
        .blkret_rrb_ack(ack), .blkret_rrb_err_ack(err), .blkret_rrb_rd_data(rdd),
        .blkret_rrb_intr(intr), .blkret_rrb_ecc_error(ecc),
        .blk_rrb_ack(ob_ack), .blk_rrb_err_ack(ob_err), .blk_rrb_rd_data(ob_rdd),
        .blk_rrb_intr(ob_intr), .blk_rrb_ecc_error(ob_ecc),
        .timeout_pulse(ob_to), .drop_pulse(ob_drop)
    );

    nx_rbus_retime_pipe #(.DW(64), .REQ_STAGES(3), .RSP_STAGES(2), .TIMEOUT(0)) dut_c (
        .clk(clk), .rst_n(rst_n),
        .rrb_blk_addr(c_addr), .rrb_blk_rd_stb(c_rd), .rrb_blk_wr_data(c_wd), .rrb_blk_wr_stb(c_wr),
        .rrb_blkret_addr(oc_addr), .rrb_blkret_rd_stb(oc_rd), .rrb_blkret_wr_data(oc_wd),
        .rrb_blkret_wr_stb(oc_wr),
        .blkret_rrb_ack(c_ack), .blkret_rrb_err_ack(c_err), .blkret_rrb_rd_data(c_rdd),
        .blkret_rrb_intr(c_intr), .blkret_rrb_ecc_error(c_ecc),
        .blk_rrb_ack(oc_ack), .blk_rrb_err_ack(oc_err), .blk_rrb_rd_data(oc_rdd),
        .blk_rrb_intr(oc_intr), .blk_rrb_ecc_error(oc_ecc),
        .timeout_pulse(oc_to), .drop_pulse(oc_drop)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct packed {
        logic [15:0] addr;
        logic [63:0] wd;
        logic        rd;
        logic        wr;
    } req_t;
    typedef struct packed {
        logic        ack;
        logic        err;
        logic [63:0] rdd;
        logic        intr;
        logic        ecc;
    } rsp_t;
    typedef enum logic [1:0] {PH_IDLE, PH_BUSY, PH_DRAIN} ph_e;

    ph_e         ph [3];
    int unsigned t_start [3];
    req_t        hreq [3][64];
    rsp_t        hrsp [3][64];
    logic [1:0]  hev  [3][64];   // {timeout event, drop event}
    int unsigned cyc = 0;

    function automatic int unsigned to_of(input int k);
        return (k == 0) ? TO_A : (k == 1) ? TO_B : 0;
    endfunction
    function automatic int unsigned req_lat(input int k);
        return (k == 2) ? 3 : 1;
    endfunction
    function automatic int unsigned rsp_lat(input int k);
        return (k == 2) ? 2 : 1;
    endfunction

    // Pipe-entry values for this cycle, derived from transaction age since its strobe.
    task automatic model_step(input int k);
        req_t ri;
        rsp_t si;
        logic [1:0] ev;
        logic stb, rsp;
        int unsigned age, to;
        to = to_of(k);
        if (k == 2) begin
            ri.addr = c_addr; ri.wd = c_wd; ri.rd = c_rd; ri.wr = c_wr;
            si.ack = c_ack; si.err = c_err; si.rdd = c_rdd; si.intr = c_intr; si.ecc = c_ecc;
        end else begin
            ri.addr = addr; ri.wd = {32'h0, wd}; ri.rd = rd_stb; ri.wr = wr_stb;
            si.ack = ack; si.err = err; si.rdd = {32'h0, rdd}; si.intr = intr; si.ecc = ecc;
        end
        ev  = 2'b00;
        stb = ri.rd | ri.wr;
        rsp = si.ack | si.err;
        age = cyc - t_start[k];
        if (!rst_n) begin
            ri = '0;
            si = '0;
            ph[k] = PH_IDLE;
        end else if (to != 0) begin
            case (ph[k])
                PH_IDLE: if (stb) begin
                    ph[k] = PH_BUSY;
                    t_start[k] = cyc;
                end
                PH_BUSY: begin
                    if (stb) begin ri.rd = 1'b0; ri.wr = 1'b0; ev[0] = 1'b1; end
                    if (rsp) ph[k] = PH_IDLE;
                    else if (age == to) begin
                        si.ack = 1'b0; si.err = 1'b1; si.rdd = 64'hDEAD_0BAD;
                        ev[1] = 1'b1;
                        ph[k] = PH_DRAIN;
                    end
                end
                default: begin
                    if (stb) begin ri.rd = 1'b0; ri.wr = 1'b0; ev[0] = 1'b1; end
                    if (rsp) begin
                        si.ack = 1'b0; si.err = 1'b0; si.rdd = '0;
                        ph[k] = PH_IDLE;
                    end else if (age == 2 * to) ph[k] = PH_IDLE;
                end
            endcase
        end
        hreq[k][cyc % 64] = ri;
        hrsp[k][cyc % 64] = si;
        hev[k][cyc % 64]  = ev;
    endtask

    task automatic compare(input int k);
        req_t er, ar;
        rsp_t es, as;
        logic [1:0] ee, ae;
        int unsigned rl, pl;
        rl = req_lat(k);
        pl = rsp_lat(k);
        er = (rst_n && cyc >= rl) ? hreq[k][(cyc - rl) % 64] : '0;
        es = (rst_n && cyc >= pl) ? hrsp[k][(cyc - pl) % 64] : '0;
        ee = (rst_n && cyc >= 1)  ? hev[k][(cyc - 1) % 64]   : 2'b00;
        if (k == 0) begin
            ar = '{oa_addr, {32'h0, oa_wd}, oa_rd, oa_wr};
            as = '{oa_ack, oa_err, {32'h0, oa_rdd}, oa_intr, oa_ecc};
            ae = {oa_to, oa_drop};
        end else if (k == 1) begin
            ar = '{ob_addr, {32'h0, ob_wd}, ob_rd, ob_wr};
            as = '{ob_ack, ob_err, {32'h0, ob_rdd}, ob_intr, ob_ecc};
            ae = {ob_to, ob_drop};
        end else begin
            ar = '{oc_addr, oc_wd, oc_rd, oc_wr};
            as = '{oc_ack, oc_err, oc_rdd, oc_intr, oc_ecc};
            ae = {oc_to, oc_drop};
        end
        check($sformatf("model_req[%0d]@%0d", k, cyc), 128'(ar), 128'(er));
        check($sformatf("model_rsp[%0d]@%0d", k, cyc), 128'(as), 128'(es));
        check($sformatf("model_status[%0d]@%0d", k, cyc), 128'(ae), 128'(ee));
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            model_step(k);
            compare(k);
        end
        cyc++;
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    initial begin
        rst_n = 1'b1;
        addr = '0; rd_stb = 0; wr_stb = 0; wd = '0; ack = 0; err = 0; rdd = '0; intr = 0; ecc = 0;
        c_addr = '0; c_rd = 0; c_wr = 0; c_wd = '0; c_ack = 0; c_err = 0; c_rdd = '0;
        c_intr = 0; c_ecc = 0;
        #1 rst_n = 1'b0;
        ticks(4);
        check("reset_outs", 128'({oa_rd, oa_ack, oa_err, oa_to, oa_drop, ob_rd, ob_ack, oc_rd, oc_ack}),
              128'(9'h0));
        rst_n = 1'b1;
        ticks(3);

        // default read, block acks 3 cycles after seeing the strobe
        addr = 16'h0040; rd_stb = 1;
        tick(); rd_stb = 0; addr = '0;
        check("t1_blkret_rd", 128'({oa_rd, oa_addr}), 128'({1'b1, 16'h0040}));
        ticks(3); ack = 1; rdd = 32'h1234_5678;
        tick(); ack = 0; rdd = '0;
        check("t1_ack", 128'({oa_ack, oa_err, oa_rdd}), 128'({1'b1, 1'b0, 32'h1234_5678}));
        check("t1_status", 128'({oa_to, oa_drop, ob_to, ob_drop}), 128'(4'h0));
        ticks(2); ecc = 1; intr = 1;
        ticks(2); ecc = 0; intr = 0;
        ticks(2);

        // watchdog fires on B; late ack swallowed by B, forwarded by A
        wr_stb = 1; addr = 16'h0080; wd = 32'hCAFE_F00D;
        tick(); wr_stb = 0;
        ticks(7);
        check("t2_no_early_to", 128'(ob_to), 128'(1'b0));
        tick();
        check("t2_to_pulse", 128'(ob_to), 128'(1'b1));
        check("t2_err", 128'({ob_ack, ob_err, ob_rdd}), 128'({1'b0, 1'b1, 32'hDEAD_0BAD}));
        check("t2_a_silent", 128'({oa_err, oa_to}), 128'(2'b00));
        ticks(3); ack = 1; rdd = 32'h0000_0055;
        tick(); ack = 0; rdd = '0;
        check("t2_late_ack_b", 128'({ob_ack, ob_err, ob_rdd}), 128'(34'h0));
        check("t2_late_ack_a", 128'({oa_ack, oa_rdd}), 128'({1'b1, 32'h0000_0055}));
        ticks(4);

        // ack exactly on the cnt==TIMEOUT cycle wins over the watchdog
        rd_stb = 1; addr = 16'h00C0;
        tick(); rd_stb = 0;
        ticks(7); ack = 1; rdd = 32'hA5A5_0003;
        tick(); ack = 0; rdd = '0;
        check("t3_ack_b", 128'({ob_ack, ob_err, ob_rdd}), 128'({1'b1, 1'b0, 32'hA5A5_0003}));
        check("t3_no_to", 128'(ob_to), 128'(1'b0));
        ticks(3);

        // second strobe while busy is dropped
        rd_stb = 1; addr = 16'h0100;
        tick(); rd_stb = 0;
        tick(); wr_stb = 1; addr = 16'h0104; wd = 32'h1111_2222;
        tick(); wr_stb = 0;
        check("t4_drop_fwd", 128'({oa_wr, ob_wr}), 128'(2'b00));
        check("t4_drop_pulse", 128'({oa_drop, ob_drop}), 128'(2'b11));
        ack = 1; rdd = 32'h7777_0004;
        tick(); ack = 0; rdd = '0;
        check("t4_ack", 128'({oa_ack, ob_ack, oa_rdd}), 128'({1'b1, 1'b1, 32'h7777_0004}));
        ticks(3);

        // reset while busy, late ack forwarded as unsolicited
        rd_stb = 1; addr = 16'h0200;
        tick(); rd_stb = 0;
        tick(); rst_n = 0; intr = 1;
        tick();
        check("t6_in_reset", 128'({oa_intr, ob_intr, oa_rd, oa_ack, ob_to}), 128'(5'h0));
        ticks(3); rst_n = 1;
        tick(); ack = 1; rdd = 32'h0000_6666;
        tick(); ack = 0; rdd = '0; intr = 0;
        check("t6_unsol", 128'({oa_ack, ob_ack, oa_rdd, oa_intr}), 128'({1'b1, 1'b1, 32'h0000_6666, 1'b1}));
        ticks(3);

        // pure retime instance: both strobes at once, 3-cycle request latency
        c_rd = 1; c_wr = 1; c_addr = 16'h0ABC; c_wd = 64'h0123_4567_89AB_CDEF;
        tick(); c_rd = 0; c_wr = 0; c_addr = '0; c_wd = '0;
        tick();
        check("t5_req_early", 128'({oc_rd, oc_wr}), 128'(2'b00));
        tick();
        check("t5_req", 128'({oc_rd, oc_wr, oc_addr, oc_wd}),
              128'({1'b1, 1'b1, 16'h0ABC, 64'h0123_4567_89AB_CDEF}));
        ticks(20);
        check("t5_no_err", 128'({oc_err, oc_to, oc_drop}), 128'(3'b000));
        c_wr = 1; c_addr = 16'h0AC0;
        tick(); c_addr = 16'h0AC4;
        tick(); c_wr = 0; c_addr = '0;
        tick();
        check("t5_b2b_first", 128'({oc_wr, oc_addr}), 128'({1'b1, 16'h0AC0}));
        tick();
        check("t5_b2b_second", 128'({oc_wr, oc_addr, oc_drop}), 128'({1'b1, 16'h0AC4, 1'b0}));
        c_ack = 1; c_rdd = 64'hFEDC_BA98_7654_3210; c_intr = 1;
        tick(); c_ack = 0; c_rdd = '0;
        check("t5_rsp_early", 128'({oc_ack, oc_intr}), 128'(2'b00));
        tick(); c_intr = 0;
        check("t5_rsp", 128'({oc_ack, oc_err, oc_rdd, oc_intr}),
              128'({1'b1, 1'b0, 64'hFEDC_BA98_7654_3210, 1'b1}));
        ticks(2);
        check("t5_intr_low", 128'(oc_intr), 128'(1'b0));
        ticks(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
